// File: rtl/vcve2_pkg.sv
// Shared types and constants for the vcve2 vector unit.
// Holds LMUL encoding, AGU state type and VRF address-map helpers.
package vcve2_pkg;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_1_8  = 3'b101,
    LMUL_1_4  = 3'b110,
    LMUL_1_2  = 3'b111
  } vlmul_e;

  typedef enum logic [1:0] {
    AGU_IDLE,
    AGU_CALC,
    AGU_READY
  } agu_state_t;

  localparam logic [31:0] VRF_BASE_ADDR = 32'h1000_0000;

  // Bytes spanned by one register group; fractional groups never shrink below one beat.
  function automatic logic [31:0] agu_group_limit(vlmul_e lmul, logic [31:0] vlenb,
                                                  logic [31:0] step);
    logic [2:0]  l;
    logic [2:0]  sh;
    logic [31:0] frac;
    logic [31:0] res;
    l    = lmul;
    sh   = ~l + 3'd1;
    frac = vlenb >> sh;
    if (!l[2]) begin
      res = vlenb << l;
    end else if (frac < step) begin
      res = step;
    end else begin
      res = frac;
    end
    return res;
  endfunction

  function automatic logic agu_misaligned(vlmul_e lmul, logic [31:0] idx);
    logic [2:0]  l;
    logic [31:0] mask;
    l    = lmul;
    mask = (32'd1 << l) - 32'd1;
    return !l[2] && (l != 3'd0) && ((idx & mask) != 32'd0);
  endfunction

endpackage

// File: rtl/vcve2_vrf_agu_if.sv
// Request/response bundle between the VRF interface FSM and the AGU.
// master = FSM side, slave = AGU side.
interface vcve2_vrf_agu_if #(
  parameter int unsigned AddrWidth = 5
);
  import vcve2_pkg::*;

  logic                 load_i;
  logic [AddrWidth-1:0] raddr_a_i;
  logic [AddrWidth-1:0] raddr_b_i;
  logic [AddrWidth-1:0] waddr_i;
  vlmul_e               lmul_i;
  logic                 get_rs1_i;
  logic                 get_rs2_i;
  logic                 get_rd_noincr_i;
  logic                 get_rd_i;
  logic                 ready_o;
  logic [31:0]          data_addr_o;
  logic                 addr_err_o;

  modport master (
    output load_i, raddr_a_i, raddr_b_i, waddr_i, lmul_i,
           get_rs1_i, get_rs2_i, get_rd_noincr_i, get_rd_i,
    input  ready_o, data_addr_o, addr_err_o
  );

  modport slave (
    input  load_i, raddr_a_i, raddr_b_i, waddr_i, lmul_i,
           get_rs1_i, get_rs2_i, get_rd_noincr_i, get_rd_i,
    output ready_o, data_addr_o, addr_err_o
  );

endinterface

// File: rtl/vcve2_agu_ptr.sv
// One operand pointer: latched index, group base address, running beat offset
// and a flag recording that the offset has wrapped past the group end.
module vcve2_agu_ptr #(
  parameter int unsigned VLEN        = 128,
  parameter int unsigned PIPE_WIDTH  = 32,
  parameter int unsigned AddrWidth   = 5,
  parameter logic [31:0] VrfBaseAddr = vcve2_pkg::VRF_BASE_ADDR,
  parameter int unsigned OffW        = $clog2(VLEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] idx_i,
  input  logic                 calc_i,
  input  logic                 incr_i,
  input  logic [OffW-1:0]      limit_i,
  output logic [31:0]          addr_o,
  output logic                 wrap_o
);

  localparam int unsigned VlenbLog2 = $clog2(VLEN / 8);
  localparam logic [OffW:0] Step    = (OffW + 1)'(PIPE_WIDTH / 8);

  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [31:0]          base_q, base_d;
  logic [OffW-1:0]      off_q, off_d;
  logic                 wrap_q, wrap_d;
  logic [OffW:0]        off_next;

  always_comb begin
    idx_d    = idx_q;
    base_d   = base_q;
    off_d    = off_q;
    wrap_d   = wrap_q;
    off_next = {1'b0, off_q} + Step;
    if (load_i) begin
      idx_d  = idx_i;
      off_d  = '0;
      wrap_d = 1'b0;
    end else begin
      if (calc_i) begin
        base_d = VrfBaseAddr + (32'(idx_q) << VlenbLog2);
      end
      if (incr_i) begin
        if (off_next >= {1'b0, limit_i}) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_next[OffW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      base_q <= '0;
      off_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      off_q  <= off_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o = base_q + 32'(off_q);
  assign wrap_o = wrap_q;

endmodule

// File: rtl/vcve2_vrf_agu.sv
// VRF address generation unit: load/calc/ready FSM, group limit, get priority
// mux and sticky misalignment/overrun error.
module vcve2_vrf_agu
  import vcve2_pkg::*;
#(
  parameter int unsigned VLEN        = 128,
  parameter int unsigned PIPE_WIDTH  = 32,
  parameter int unsigned AddrWidth   = 5,
  parameter logic [31:0] VrfBaseAddr = VRF_BASE_ADDR
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vcve2_vrf_agu_if.slave agu
);

  localparam int unsigned OffW  = $clog2(VLEN) + 1;
  localparam logic [31:0] Vlenb = 32'(VLEN / 8);
  localparam logic [31:0] Step  = 32'(PIPE_WIDTH / 8);

  agu_state_t      state_q, state_d;
  vlmul_e          lmul_q, lmul_d;
  logic            misalign_q, misalign_d;
  logic [OffW-1:0] limit_q, limit_d;
  logic            err_q, err_d;

  logic        calc;
  logic        incr_a, incr_b, incr_d;
  logic [31:0] addr_a, addr_b, addr_d;
  logic        wrap_a, wrap_b, wrap_d;
  logic [31:0] data_addr;
  logic        hit_wrap;

  always_comb begin
    state_d    = state_q;
    lmul_d     = lmul_q;
    misalign_d = misalign_q;
    limit_d    = limit_q;
    err_d      = err_q;
    calc       = 1'b0;
    incr_a     = 1'b0;
    incr_b     = 1'b0;
    incr_d     = 1'b0;
    data_addr  = '0;
    hit_wrap   = 1'b0;

    case (state_q)
      AGU_CALC: begin
        calc    = 1'b1;
        limit_d = OffW'(agu_group_limit(lmul_q, Vlenb, Step));
        err_d   = err_q | misalign_q;
        state_d = AGU_READY;
      end
      AGU_READY: begin
        if (!agu.load_i) begin
          if (agu.get_rs1_i) begin
            data_addr = addr_a;
            incr_a    = 1'b1;
            hit_wrap  = wrap_a;
          end else if (agu.get_rs2_i) begin
            data_addr = addr_b;
            incr_b    = 1'b1;
            hit_wrap  = wrap_b;
          end else if (agu.get_rd_noincr_i) begin
            data_addr = addr_d;
            hit_wrap  = wrap_d;
          end else if (agu.get_rd_i) begin
            data_addr = addr_d;
            incr_d    = 1'b1;
            hit_wrap  = wrap_d;
          end
        end
        if (hit_wrap) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Load overrides everything above, from any state; misalignment is
    // captured now and folded into the error during CALC.
    if (agu.load_i) begin
      state_d    = AGU_CALC;
      lmul_d     = agu.lmul_i;
      misalign_d = agu_misaligned(agu.lmul_i, 32'(agu.raddr_a_i)) |
                   agu_misaligned(agu.lmul_i, 32'(agu.raddr_b_i)) |
                   agu_misaligned(agu.lmul_i, 32'(agu.waddr_i));
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= AGU_IDLE;
      lmul_q     <= LMUL_1;
      misalign_q <= 1'b0;
      limit_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lmul_q     <= lmul_d;
      misalign_q <= misalign_d;
      limit_q    <= limit_d;
      err_q      <= err_d;
    end
  end

  vcve2_agu_ptr #(
    .VLEN        (VLEN),
    .PIPE_WIDTH  (PIPE_WIDTH),
    .AddrWidth   (AddrWidth),
    .VrfBaseAddr (VrfBaseAddr),
    .OffW        (OffW)
  ) u_ptr_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (agu.load_i),
    .idx_i   (agu.raddr_a_i),
    .calc_i  (calc),
    .incr_i  (incr_a),
    .limit_i (limit_q),
    .addr_o  (addr_a),
    .wrap_o  (wrap_a)
  );

  vcve2_agu_ptr #(
    .VLEN        (VLEN),
    .PIPE_WIDTH  (PIPE_WIDTH),
    .AddrWidth   (AddrWidth),
    .VrfBaseAddr (VrfBaseAddr),
    .OffW        (OffW)
  ) u_ptr_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (agu.load_i),
    .idx_i   (agu.raddr_b_i),
    .calc_i  (calc),
    .incr_i  (incr_b),
    .limit_i (limit_q),
    .addr_o  (addr_b),
    .wrap_o  (wrap_b)
  );

  vcve2_agu_ptr #(
    .VLEN        (VLEN),
    .PIPE_WIDTH  (PIPE_WIDTH),
    .AddrWidth   (AddrWidth),
    .VrfBaseAddr (VrfBaseAddr),
    .OffW        (OffW)
  ) u_ptr_d (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (agu.load_i),
    .idx_i   (agu.waddr_i),
    .calc_i  (calc),
    .incr_i  (incr_d),
    .limit_i (limit_q),
    .addr_o  (addr_d),
    .wrap_o  (wrap_d)
  );

  assign agu.ready_o     = (state_q == AGU_READY);
  assign agu.data_addr_o = data_addr;
  assign agu.addr_err_o  = err_q;

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Directed scoreboard bench for vcve2_vrf_agu: expected beat addresses are
// queued as gets are driven and compared in the same cycle's second half.
module tb_vcve2_vrf_agu;
  import vcve2_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vcve2_vrf_agu_if #(.AddrWidth(5)) agu_if ();

  vcve2_vrf_agu #(
    .VLEN        (128),
    .PIPE_WIDTH  (32),
    .AddrWidth   (5),
    .VrfBaseAddr (32'h1000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .agu   (agu_if)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_gets();
    agu_if.get_rs1_i       = 1'b0;
    agu_if.get_rs2_i       = 1'b0;
    agu_if.get_rd_noincr_i = 1'b0;
    agu_if.get_rd_i        = 1'b0;
  endtask

  // kind: 0 rs1, 1 rs2, 2 rd_noincr, 3 rd
  task automatic drive_get(input int kind);
    clear_gets();
    case (kind)
      0: agu_if.get_rs1_i = 1'b1;
      1: agu_if.get_rs2_i = 1'b1;
      2: agu_if.get_rd_noincr_i = 1'b1;
      default: agu_if.get_rd_i = 1'b1;
    endcase
  endtask

  task automatic get_beat(input string tag, input int kind, input logic [31:0] exp_addr);
    drive_get(kind);
    exp_q.push_back(exp_addr);
    @(negedge clk);
    check(tag, agu_if.data_addr_o, exp_q.pop_front());
    tick();
    clear_gets();
  endtask

  task automatic start_load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                            input vlmul_e lmul);
    agu_if.load_i    = 1'b1;
    agu_if.raddr_a_i = a;
    agu_if.raddr_b_i = b;
    agu_if.waddr_i   = d;
    agu_if.lmul_i    = lmul;
  endtask

  // Returns at the start of T+2, the first READY cycle.
  task automatic do_load(input string tag, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input vlmul_e lmul, input logic exp_err);
    start_load(a, b, d, lmul);
    tick();
    agu_if.load_i = 1'b0;
    check({tag, "_ready_t1"}, 32'(agu_if.ready_o), 32'd0);
    check({tag, "_err_t1"}, 32'(agu_if.addr_err_o), 32'd0);
    tick();
    check({tag, "_ready_t2"}, 32'(agu_if.ready_o), 32'd1);
    check({tag, "_err_t2"}, 32'(agu_if.addr_err_o), 32'(exp_err));
  endtask

  initial begin
    rst              = 1'b1;
    agu_if.load_i    = 1'b0;
    agu_if.raddr_a_i = '0;
    agu_if.raddr_b_i = '0;
    agu_if.waddr_i   = '0;
    agu_if.lmul_i    = LMUL_1;
    clear_gets();
    tick();
    tick();
    check("rst_ready", 32'(agu_if.ready_o), 32'd0);
    check("rst_addr", agu_if.data_addr_o, 32'd0);
    check("rst_err", 32'(agu_if.addr_err_o), 32'd0);
    rst = 1'b0;
    tick();
    get_beat("idle_get", 0, 32'h0);

    // Basic addressing and vd read-modify-write
    do_load("basic", 5'd2, 5'd5, 5'd7, LMUL_1, 1'b0);
    get_beat("rs1_b0", 0, 32'h1000_0020);
    get_beat("rs1_b1", 0, 32'h1000_0024);
    get_beat("rs2_b0", 1, 32'h1000_0050);
    get_beat("rd_noincr", 2, 32'h1000_0070);
    get_beat("rd_b0", 3, 32'h1000_0070);
    get_beat("rd_b1", 3, 32'h1000_0074);
    check("basic_err", 32'(agu_if.addr_err_o), 32'd0);

    // LMUL=4: misaligned group, then a full group walk and overrun
    do_load("mis", 5'd3, 5'd4, 5'd8, LMUL_4, 1'b1);
    do_load("lmul4", 5'd4, 5'd8, 5'd12, LMUL_4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      get_beat("lmul4_beat", 0, 32'h1000_0040 + 32'(i * 4));
    end
    check("lmul4_err_before", 32'(agu_if.addr_err_o), 32'd0);
    get_beat("lmul4_wrap", 0, 32'h1000_0040);
    check("lmul4_err_after", 32'(agu_if.addr_err_o), 32'd1);

    // Fractional LMUL=1/4: one-beat group
    do_load("frac", 5'd1, 5'd0, 5'd0, LMUL_1_4, 1'b0);
    get_beat("frac_b0", 0, 32'h1000_0010);
    check("frac_err0", 32'(agu_if.addr_err_o), 32'd0);
    get_beat("frac_b1", 0, 32'h1000_0010);
    check("frac_err1", 32'(agu_if.addr_err_o), 32'd1);

    // Reload in READY with error set; get with load, get in CALC
    start_load(5'd2, 5'd3, 5'd4, LMUL_1);
    drive_get(0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("load_get_addr", agu_if.data_addr_o, exp_q.pop_front());
    check("load_err_held", 32'(agu_if.addr_err_o), 32'd1);
    tick();
    agu_if.load_i = 1'b0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("calc_get_addr", agu_if.data_addr_o, exp_q.pop_front());
    check("calc_ready", 32'(agu_if.ready_o), 32'd0);
    check("calc_err_clr", 32'(agu_if.addr_err_o), 32'd0);
    tick();
    clear_gets();
    check("reload_ready", 32'(agu_if.ready_o), 32'd1);
    get_beat("reload_rs1", 0, 32'h1000_0020);
    get_beat("reload_rs2", 1, 32'h1000_0030);
    get_beat("reload_rd", 3, 32'h1000_0040);

    // Mid-stream reset with error set, then restart
    do_load("pre_rst", 5'd1, 5'd0, 5'd0, LMUL_1_4, 1'b0);
    get_beat("pre_rst_b0", 0, 32'h1000_0010);
    get_beat("pre_rst_b1", 0, 32'h1000_0010);
    get_beat("pre_rst_b2", 0, 32'h1000_0010);
    check("pre_rst_err", 32'(agu_if.addr_err_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(agu_if.ready_o), 32'd0);
    check("mid_rst_addr", agu_if.data_addr_o, 32'd0);
    check("mid_rst_err", 32'(agu_if.addr_err_o), 32'd0);
    do_load("post_rst", 5'd1, 5'd2, 5'd3, LMUL_1, 1'b0);
    get_beat("post_rst_b0", 0, 32'h1000_0010);
    get_beat("post_rst_b1", 0, 32'h1000_0014);
    get_beat("post_rst_rd", 2, 32'h1000_0030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
